// File: rtl/dcnt200.sv
// -----------------------------------------------------------------------------
// dcnt200 -- presettable modulo-200 down-counter, one-shot / auto-wrap modes.
//
// Counting-down companion of the mod-200 up-counter. The 8-bit binary count is
// presented as two nibbles {QH,QL}. Load is active-low and synchronous, and
// counting is enabled by CEP & CET. TC is a combinational borrow for cascading:
// the upstream TC drives the downstream CEP.
//
// Ports
//   Clk   in   1  rising-edge clock
//   MR    in   1  asynchronous active-low master reset
//   PE    in   1  active-low synchronous parallel load
//   D     in   8  load value, clamped to 199
//   CEP   in   1  count enable, parallel
//   CET   in   1  count enable, trickle; also gates TC
//   MODE  in   1  0 = auto-wrap, 1 = one-shot (stop at 0)
//   QH    out  4  count[7:4]
//   QL    out  4  count[3:0]
//   TC    out  1  (count == 0) & CET, combinational
//   DONE  out  1  one-cycle pulse when a one-shot run ends
//   BUSY  out  1  high while in RUN
//
// State | meaning
// ------+-----------------------------------------------------------
// HALT  | counting blocked regardless of enables; only a load leaves
// RUN   | decrements on every edge with CEP & CET high
// -----------------------------------------------------------------------------
module dcnt200 (
    input  logic       Clk,
    input  logic       MR,
    input  logic       PE,
    input  logic [7:0] D,
    input  logic       CEP,
    input  logic       CET,
    input  logic       MODE,
    output logic [3:0] QH,
    output logic [3:0] QL,
    output logic       TC,
    output logic       DONE,
    output logic       BUSY
);

    localparam logic [7:0] MAX_CNT = 8'd199;

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] count;
    logic [7:0] load_val;
    logic       cnt_en;
    logic       load_halts;

    assign load_val   = (D > MAX_CNT) ? MAX_CNT : D;
    assign cnt_en     = CEP & CET;
    // A one-shot loaded with zero has nothing to count: park without a DONE.
    assign load_halts = MODE & (load_val == 8'd0);

    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            count <= 8'd0;
            state <= HALT;
            DONE  <= 1'b0;
        end else begin
            // DONE is a single-cycle pulse; any edge that does not end a
            // one-shot clears it, including a load colliding with the end.
            DONE <= 1'b0;
            if (!PE) begin
                count <= load_val;
                state <= load_halts ? HALT : RUN;
            end else if ((state == RUN) && cnt_en) begin
                if (!MODE) begin
                    count <= (count == 8'd0) ? MAX_CNT : count - 8'd1;
                end else if (count > 8'd1) begin
                    count <= count - 8'd1;
                end else begin
                    // count of 1 reaches zero now; a count already at 0
                    // (MODE switched to one-shot mid-run) ends immediately.
                    count <= 8'd0;
                    state <= HALT;
                    DONE  <= 1'b1;
                end
            end
        end
    end

    assign QH   = count[7:4];
    assign QL   = count[3:0];
    assign BUSY = (state == RUN);
    assign TC   = (count == 8'd0) & CET;

endmodule

// File: tb/tb_dcnt200.sv
module tb_dcnt200;

    logic       Clk = 1'b0;
    logic       MR  = 1'b0;
    logic       PE  = 1'b1;
    logic [7:0] D   = 8'd0;
    logic       CEP = 1'b0;
    logic       CET = 1'b1;
    logic       MODE = 1'b0;
    logic [3:0] QH, QL;
    logic       TC, DONE, BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    dcnt200 dut (
        .Clk (Clk),
        .MR  (MR),
        .PE  (PE),
        .D   (D),
        .CEP (CEP),
        .CET (CET),
        .MODE(MODE),
        .QH  (QH),
        .QL  (QL),
        .TC  (TC),
        .DONE(DONE),
        .BUSY(BUSY)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic       pe;
        logic [7:0] d;
        logic       cep;
        logic       cet;
        logic       mode;
        logic [7:0] q;
        logic       busy;
        logic       done;
        logic       tc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic pe, input int d,
                       input logic cep, input logic cet, input logic mode,
                       input int q, input logic busy, input logic done,
                       input logic tc);
        vec_t v;
        v.name = name; v.pe = pe; v.d = d[7:0]; v.cep = cep; v.cet = cet;
        v.mode = mode; v.q = q[7:0]; v.busy = busy; v.done = done; v.tc = tc;
        tbl.push_back(v);
    endtask

    // Drive one vector away from the edge, record its expectation, then
    // compare once the DUT has taken the edge.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge Clk);
        PE = v.pe; D = v.d; CEP = v.cep; CET = v.cet; MODE = v.mode;
        sb.push_back(v);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk({e.name, ".count"}, int'({QH, QL}), int'(e.q));
        chk({e.name, ".busy"},  int'(BUSY),     int'(e.busy));
        chk({e.name, ".done"},  int'(DONE),     int'(e.done));
        chk({e.name, ".tc"},    int'(TC),       int'(e.tc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;

        // Reset state, TC follows CET while reset.
        #2;
        chk("rst.count", int'({QH, QL}), 0);
        chk("rst.busy",  int'(BUSY), 0);
        chk("rst.done",  int'(DONE), 0);
        chk("rst.tc1",   int'(TC), 1);
        CET = 1'b0;
        #1;
        chk("rst.tc0",   int'(TC), 0);
        @(negedge Clk);
        MR = 1'b1;
        CET = 1'b1;

        //      name        pe  d    cep  cet  mode  q    busy done tc
        add("os_load",     0,  5,   1,   1,   1,    5,   1,   0,   0);
        add("os_4",        1,  0,   1,   1,   1,    4,   1,   0,   0);
        add("os_3",        1,  0,   1,   1,   1,    3,   1,   0,   0);
        add("os_2",        1,  0,   1,   1,   1,    2,   1,   0,   0);
        add("os_1",        1,  0,   1,   1,   1,    1,   1,   0,   0);
        add("os_0",        1,  0,   1,   1,   1,    0,   0,   1,   1);
        add("wr_load",     0,  2,   1,   1,   0,    2,   1,   0,   0);
        add("wr_1",        1,  0,   1,   1,   0,    1,   1,   0,   0);
        add("wr_0",        1,  0,   1,   1,   0,    0,   1,   0,   1);
        add("wr_199",      1,  0,   1,   1,   0,    199, 1,   0,   0);
        add("wr_198",      1,  0,   1,   1,   0,    198, 1,   0,   0);
        add("clamp",       0,  250, 1,   1,   0,    199, 1,   0,   0);
        add("zero_os",     0,  0,   1,   1,   1,    0,   0,   0,   1);
        add("halt_hold",   1,  0,   1,   1,   0,    0,   0,   0,   1);
        add("en_load40",   0,  40,  1,   1,   0,    40,  1,   0,   0);
        add("cep0_a",      1,  0,   0,   1,   0,    40,  1,   0,   0);
        add("cep0_b",      1,  0,   0,   1,   0,    40,  1,   0,   0);
        add("cep0_c",      1,  0,   0,   1,   0,    40,  1,   0,   0);
        add("cet0_hold",   1,  0,   1,   0,   0,    40,  1,   0,   0);
        add("load7_cep0",  0,  7,   0,   1,   0,    7,   1,   0,   0);
        add("load0_wrap",  0,  0,   1,   1,   0,    0,   1,   0,   1);
        add("cet0_at0_a",  1,  0,   1,   0,   0,    0,   1,   0,   0);
        add("cet0_at0_b",  1,  0,   1,   0,   0,    0,   1,   0,   0);
        add("col_load2",   0,  2,   1,   1,   1,    2,   1,   0,   0);
        add("col_1",       1,  0,   1,   1,   1,    1,   1,   0,   0);
        add("col_load9",   0,  9,   1,   1,   1,    9,   1,   0,   0);
        add("col_8",       1,  0,   1,   1,   1,    8,   1,   0,   0);
        add("sw_load0",    0,  0,   1,   1,   0,    0,   1,   0,   1);
        add("sw_mode1",    1,  0,   1,   1,   1,    0,   0,   1,   1);
        add("sw_after",    1,  0,   1,   1,   1,    0,   0,   0,   1);
        add("os1_load",    0,  1,   1,   1,   1,    1,   1,   0,   0);
        add("os1_end",     1,  0,   1,   1,   1,    0,   0,   1,   1);
        add("os1_idle",    1,  0,   0,   0,   1,    0,   0,   0,   0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // One-shot completion followed by ten idle edges holding zero.
        v.name = "os_load2"; v.pe = 0; v.d = 8'd5; v.cep = 1; v.cet = 1;
        v.mode = 1; v.q = 8'd5; v.busy = 1; v.done = 0; v.tc = 0;
        apply(v);
        v.pe = 1;
        for (int k = 4; k >= 0; k--) begin
            v.name = "os_run2"; v.q = k[7:0];
            v.busy = (k != 0); v.done = (k == 0); v.tc = (k == 0);
            apply(v);
        end
        for (int k = 0; k < 10; k++) begin
            v.name = "os_post"; v.q = 8'd0; v.busy = 0; v.done = 0; v.tc = 1;
            apply(v);
        end

        // Reset in the middle of a wrap-mode run.
        v.name = "mr_load"; v.pe = 0; v.d = 8'd100; v.cep = 1; v.cet = 1;
        v.mode = 0; v.q = 8'd100; v.busy = 1; v.done = 0; v.tc = 0;
        apply(v);
        v.pe = 1;
        for (int k = 1; k <= 10; k++) begin
            v.name = "mr_run"; v.q = 8'(100 - k);
            apply(v);
        end
        #2;
        MR = 1'b0;
        #1;
        chk("mr.count", int'({QH, QL}), 0);
        chk("mr.busy",  int'(BUSY), 0);
        chk("mr.done",  int'(DONE), 0);
        chk("mr.tc1",   int'(TC), 1);
        CET = 1'b0;
        #1;
        chk("mr.tc0",   int'(TC), 0);
        @(negedge Clk);
        MR = 1'b1;
        v.name = "mr_after"; v.pe = 1; v.cep = 1; v.cet = 1; v.mode = 0;
        v.q = 8'd0; v.busy = 0; v.done = 0; v.tc = 1;
        apply(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcnt200.md
# dcnt200

Presettable modulo-200 down-counter with one-shot and auto-wrap modes. It is the counting-down companion to the mod-200 up-counter in the counter library. It presents its count as two 4-bit nibbles and keeps the same load and enable semantics: active-low synchronous parallel enable, plus CEP/CET count enables. Intended uses are interval timing and cascading with the up-counter chain.

## Interface
- No parameters; modulus fixed at 200 (count range 0..199).
- Clk  in  1  rising-edge clock; the only clock.
- MR  in  1  asynchronous active-low master reset.
- PE  in  1  active-low synchronous parallel load.
- D  in  8  binary load value; values above 199 are clamped.
- CEP  in  1  count enable, parallel.
- CET  in  1  count enable, trickle; also gates TC.
- MODE  in  1  0 = auto-wrap, 1 = one-shot (stop at 0).
- QH  out  4  count[7:4].
- QL  out  4  count[3:0].
- TC  out  1  terminal count (borrow): (count == 0) & CET, combinational.
- DONE  out  1  registered one-cycle pulse when a one-shot run ends.
- BUSY  out  1  1 while in RUN state.

## Operation
- Internal 8-bit binary count; {QH,QL} = count. Example: 199 = QH 0xC, QL 0x7.
- States:
  - HALT: counting blocked regardless of enables.
  - RUN: counts when CEP & CET.
- Priority, highest first: MR low > PE low (load) > decrement > hold.
- Load (PE = 0 at a rising edge):
  - count <= min(D, 199).
  - Next state:
    - MODE = 1 and loaded value 0: HALT, no DONE pulse.
    - Otherwise: RUN.
  - Load works in both states and ignores CEP/CET.
- RUN, MODE = 0, CEP & CET = 1:
  - count > 0: count <= count - 1.
  - count == 0: count <= 199 (wrap).
- RUN, MODE = 1, CEP & CET = 1:
  - count > 1: decrement.
  - count == 1: count <= 0, state <= HALT, DONE <= 1.
  - count == 0 (only reachable by switching MODE to 1 mid-run): count holds at 0, state <= HALT, DONE <= 1.
- CEP & CET = 0: count, state and MODE effect all hold; DONE <= 0.
- HALT: count holds; only a load leaves HALT.
- DONE is high for exactly one cycle per one-shot completion. It is cleared on every other edge.
- TC is independent of state and MODE. CET = 0 forces TC = 0.
- MODE is sampled every edge; changing it mid-run takes effect at the next edge.

## Timing
- Reset while MR is low, immediate and clock-independent:
  - count = 0, QH = 0, QL = 0.
  - state = HALT, BUSY = 0, DONE = 0.
  - TC = CET.
- Reset mid-run aborts the run with no DONE pulse. Operation resumes at the first rising edge after MR deasserts, which must be synchronous to Clk.
- Load latency is one edge: QH/QL show min(D,199) after the load edge. BUSY updates on the same edge.
- Decrement latency is one edge per count. An N-count one-shot loaded with N ≥ 1 asserts DONE N enabled edges after the load edge, coincident with count reaching 0.
- TC follows count and CET combinationally with no registered delay. For cascading, the upstream TC drives the downstream CEP.
- PE low at the same edge as a one-shot reaching 0: the load wins, DONE stays 0, and the state goes to RUN.
- All outputs except TC are registered.

## Test plan
- Reset mid-run: load 100 with MODE 0, count 10 edges, pull MR low between edges. Required: QH/QL = 0, BUSY = 0, DONE = 0 before the next edge, and TC = CET.
- One-shot: MODE 1, load 5, CEP = CET = 1. Required:
  - Count sequence 5, 4, 3, 2, 1, 0.
  - DONE high for the single cycle where count first reads 0, BUSY falling on that same edge.
  - 10 further edges hold 0 with DONE = 0.
- Wrap: MODE 0, load 2. Required:
  - Sequence 2, 1, 0, 199 (QH 0xC, QL 0x7), 198.
  - TC = 1 only during the count-0 cycle; DONE never asserts.
- Clamp and zero-load: load D = 250 gives 199 and BUSY = 1. Load D = 0 with MODE 1 gives HALT, BUSY = 0, no DONE.
- Enables: at count 40 in RUN:
  - CEP = 0 for 3 edges holds at 40.
  - CET = 0 holds the count and keeps TC = 0 even at count 0.
  - PE = 0 with D = 7 and CEP = 0 loads 7.
- Collision: one-shot at count 1 with PE = 0 and D = 9 on the same edge. Required: count 9, BUSY = 1, DONE = 0.
